instr_fetch_q: RTL and testbench
================================

# instr_fetch_q

Instruction-memory receive side for the 16-bit CPU. It samples the `we_IM`/`codein`/`immd` load strobes driven by a program source and buffers each instruction word in an in-order queue. For JUMP words it also captures the trailing 12-bit immediate address. Queued words go to the decode stage over a valid/ready handshake.

## Interface
- `DEPTH`, 8: queue entries; power of two, minimum 2.
- `IMM_WAIT`, 1: cycles to wait after a JUMP word is captured before sampling `immd`; range 1–15.
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high; clears all state.
- `en`  in  1  block enable; when low, load strobes are ignored.
- `we_IM`  in  1  load strobe, level signal; each rising edge is one word.
- `codein`  in  16  instruction word; sampled in the cycle the `we_IM` rising edge is detected.
- `immd`  in  12  jump target; sampled `IMM_WAIT` cycles after a JUMP capture.
- `instr_valid`  out  1  head entry available.
- `instr_ready`  in  1  consumer accepts the head entry.
- `instr_out`  out  16  head instruction word.
- `instr_immd`  out  12  head immediate; 12'h000 for non-JUMP words.
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.

## Operation
- Edge detect: keep a 1-cycle registered copy of `we_IM`. A strobe is `we_IM & ~we_q & en`. A level held high for several cycles produces exactly one strobe.
- JUMP decode: `codein[15:12]==4'h7 && codein[11:8]==4'h1`. Example: 16'h7111 is a JUMP; 16'h7021 is not.
- FSM states:
  - IDLE:
    - On a non-JUMP strobe, push {`codein`, 12'h000}; stay in IDLE.
    - On a JUMP strobe, latch `codein`, load the wait counter with `IMM_WAIT`, go to WAIT_IMM.
  - WAIT_IMM:
    - Decrement the counter each cycle. At 0, latch `immd` and go to PUSH.
    - Strobes in this state are dropped.
    - `en` low returns the FSM to IDLE and discards the pending JUMP.
  - PUSH: push {jump word, latched immd}; go to IDLE.
- Queue: circular buffer with read and write pointers of width log2(`DEPTH`), plus a count register of width log2(`DEPTH`)+1.
  - Pointers wrap from `DEPTH`-1 to 0.
- A push is accepted if `!full`, or if a pop occurs in the same cycle.
- Pop condition: `instr_valid & instr_ready`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push while full with no pop: the word is dropped. In PUSH, the FSM still returns to IDLE.
- Outputs `instr_out` and `instr_immd` reflect the head entry combinationally from the storage array.

## Timing
- Reset values:
  - `instr_valid`=0, `empty`=1, `full`=0, `instr_out`=16'h0000, `instr_immd`=12'h000.
  - FSM in IDLE; pointers, count and `we_q` all 0.
- Non-JUMP latency: strobe detected at edge N; `instr_valid` is high after edge N+1.
- JUMP latency: strobe at edge N; `immd` sampled at edge N+`IMM_WAIT`; `instr_valid` high after edge N+`IMM_WAIT`+1.
- `instr_valid` falls in the cycle after the last entry is popped.
- Asserting `rst` at any point, including mid-WAIT_IMM, clears the state immediately with no clock required. Queued words are lost.
- `en` low does not stop draining: pops continue normally.

## Configuration
- `IFQ_STATUS_EN` defined: adds two outputs.
  - `count` (log2(`DEPTH`)+1 bits): current occupancy.
  - `overflow` (1 bit): sticky flag, set when a push is dropped because the queue is full. Cleared only by `rst`. Reset value 0.
- `IFQ_STATUS_EN` undefined: neither port exists. Dropped pushes are silent. Queue behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg` holds:
  - `OP_JUMP` = 4'h7 and `JUMP_SUB` = 4'h1;
  - the FSM state enum {IDLE, WAIT_IMM, PUSH};
  - the entry typedef {word[15:0], imm[11:0]}.
- One sub-module, `ifq_fifo`: storage, pointers, count, full/empty. The top level holds the edge detect and the FSM.

## Test plan
- After reset, `en`=1, strobe `codein`=16'h6001 with `instr_ready`=0 → `instr_valid` high two edges later; `instr_out`=16'h6001, `instr_immd`=12'h000.
- Strobe 16'h7111, then set `immd`=12'hFEB within `IMM_WAIT` cycles → a single entry {16'h7111, 12'hFEB}. Strobe 16'h7021 → `instr_immd`=12'h000.
- Hold `we_IM` high for 5 cycles with 16'h4000 → exactly one entry; count=1.
- Fill 8 words (16'h0010…16'h0017), then strobe 16'h9020 with `instr_ready`=0 → dropped; `full`=1; `overflow`=1 with `IFQ_STATUS_EN`. Then pop 8 times → words in order, `empty`=1, pointers wrapped.
- At count=8, strobe a push with `instr_ready`=1 in the same cycle → 16'h0010 popped, new word accepted, count stays 8.
- Assert `rst` during WAIT_IMM after 16'h7111 → outputs at reset values; no JUMP entry appears after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch receive side: JUMP opcode
// fields, fetch FSM states and the queued entry layout.
package cpu_pkg;

    localparam logic [3:0] OP_JUMP  = 4'h7;
    localparam logic [3:0] JUMP_SUB = 4'h1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IMM = 2'd1,
        PUSH     = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] word;
        logic [11:0] imm;
    } entry_t;

    // A JUMP word carries its 12-bit target in a trailing immediate transfer
    function automatic logic is_jump(input logic [15:0] w);
        return (w[15:12] == OP_JUMP) && (w[11:8] == JUMP_SUB);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// In-order circular buffer of {word, imm} entries feeding the decode stage.
// A push is taken when there is room or when the head leaves in the same
// cycle. Optional status outputs (count, sticky overflow) exist only when
// IFQ_STATUS_EN is defined.
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] wword,
    input  logic [11:0] wimm,
    input  logic        ready,
    output logic        valid,
    output logic [15:0] rword,
    output logic [11:0] rimm,
    output logic        full,
`ifdef IFQ_STATUS_EN
    output logic [CW-1:0] count,
    output logic        overflow,
`endif
    output logic        empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop;
    logic          accept;

    assign empty  = (cnt == '0);
    assign full   = (cnt == FULL_CNT);
    assign valid  = ~empty;
    assign pop    = valid & ready;
    assign accept = push & (~full | pop);

    // Storage write; the array holds data only and is never cleared
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {wword, wimm};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head is read straight from storage; forced to zero while empty so the
    // outputs are defined out of reset without clearing the array
    assign head  = mem[rd_ptr];
    assign rword = empty ? 16'h0000 : head.word;
    assign rimm  = empty ? 12'h000  : head.imm;

`ifdef IFQ_STATUS_EN
    logic ovf_q;

    // Sticky record of any push lost to a full queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push & ~accept) begin
            ovf_q <= 1'b1;
        end
    end

    assign count    = cnt;
    assign overflow = ovf_q;
`endif

endmodule

// File: rtl/instr_fetch_q.sv
// Instruction-memory receive side: detects we_IM rising edges, captures
// instruction words (plus the trailing immediate for JUMP words) and queues
// them for decode. Define IFQ_STATUS_EN to expose count and overflow.
module instr_fetch_q
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int IMM_WAIT = 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we_IM,
    input  logic [15:0] codein,
    input  logic [11:0] immd,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_out,
    output logic [11:0] instr_immd,
    output logic        full,
`ifdef IFQ_STATUS_EN
    output logic [CW-1:0] count,
    output logic        overflow,
`endif
    output logic        empty
);

    localparam logic [3:0] IMM_CNT = 4'(IMM_WAIT);

    state_t      state;
    state_t      nxt;
    logic        we_q;
    logic        strobe;
    logic        jump_in;
    logic        pend_q;
    logic        push;
    logic        imm_take;
    logic [3:0]  cnt_q;
    logic [15:0] word_q;
    logic [11:0] imm_q;

    assign strobe   = we_IM & ~we_q & en;
    assign jump_in  = is_jump(codein);
    // The last decrement and the immediate capture share one edge
    assign imm_take = (state == WAIT_IMM) && en && (cnt_q == 4'd1);

    // Previous we_IM level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) we_q <= 1'b0;
        else     we_q <= we_IM;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // FSM next state; en low abandons a JUMP still waiting for its immediate
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (strobe && jump_in) nxt = WAIT_IMM;
            WAIT_IMM: if (!en) nxt = IDLE;
                      else if (cnt_q == 4'd1) nxt = PUSH;
            PUSH:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // FSM outputs: non-JUMP words enter one cycle after capture, JUMPs from PUSH
    always_comb begin
        push = pend_q | (state == PUSH);
    end

    // Immediate wait counter and the one-cycle pending non-JUMP push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 4'd0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= (state == IDLE) && strobe && !jump_in;
            if ((state == IDLE) && strobe && jump_in) begin
                cnt_q <= IMM_CNT;
            end else if ((state == WAIT_IMM) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Captured word and immediate; a new strobe can only follow two cycles on
    // (we_IM must fall first), so one holding register serves both paths
    always_ff @(posedge clk) begin
        if ((state == IDLE) && strobe) begin
            word_q <= codein;
            imm_q  <= 12'h000;
        end else if (imm_take) begin
            imm_q  <= immd;
        end
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wword    (word_q),
        .wimm     (imm_q),
        .ready    (instr_ready),
        .valid    (instr_valid),
        .rword    (instr_out),
        .rimm     (instr_immd),
        .full     (full),
`ifdef IFQ_STATUS_EN
        .count    (count),
        .overflow (overflow),
`endif
        .empty    (empty)
    );

endmodule

// File: tb/tb_instr_fetch_q.sv
// Self-checking bench for instr_fetch_q: a queue-based reference model tracks
// expected contents every cycle; directed steps add literal expectations.
module tb_instr_fetch_q;

    localparam int DEPTH    = 8;
    localparam int IMM_WAIT = 3;
    localparam int CW       = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        we_IM = 1'b0;
    logic [15:0] codein = 16'h0000;
    logic [11:0] immd = 12'h000;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [11:0] instr_immd;
    logic        full;
    logic        empty;
`ifdef IFQ_STATUS_EN
    logic [CW-1:0] count;
    logic        overflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_q #(.DEPTH(DEPTH), .IMM_WAIT(IMM_WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .we_IM       (we_IM),
        .codein      (codein),
        .immd        (immd),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_immd  (instr_immd),
        .full        (full),
`ifdef IFQ_STATUS_EN
        .count       (count),
        .overflow    (overflow),
`endif
        .empty       (empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [27:0] mq[$];
    int          cyc;
    logic        m_prev_we;
    bit          jact;
    int          jsample;
    logic [15:0] jword;
    bit          nj_v;
    logic [15:0] nj_word;
    bit          jp_v;
    logic [15:0] jp_word;
    logic [11:0] jp_imm;
    bit          m_ovf;
    bit          m_pop;
    bit          m_busy;
    bit          m_strobe;

    task automatic model_push(input logic [27:0] item);
        if (mq.size() < DEPTH) mq.push_back(item);
        else                   m_ovf = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            cyc = 0; m_prev_we = 1'b0; jact = 1'b0; nj_v = 1'b0; jp_v = 1'b0; m_ovf = 1'b0;
        end else begin
            cyc++;
            m_pop  = (mq.size() > 0) && instr_ready;
            m_busy = jact || jp_v;
            if (m_pop) void'(mq.pop_front());
            if (nj_v) model_push({nj_word, 12'h000});
            if (jp_v) model_push({jp_word, jp_imm});
            nj_v = 1'b0;
            jp_v = 1'b0;
            if (jact) begin
                if (!en) jact = 1'b0;
                else if (cyc == jsample) begin
                    jact = 1'b0; jp_v = 1'b1; jp_word = jword; jp_imm = immd;
                end
            end
            m_strobe = we_IM && !m_prev_we && en;
            if (m_strobe && !m_busy) begin
                if (codein[15:8] == 8'h71) begin
                    jact = 1'b1; jword = codein; jsample = cyc + IMM_WAIT;
                end else begin
                    nj_v = 1'b1; nj_word = codein;
                end
            end
            m_prev_we = we_IM;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid", 32'(instr_valid), 32'(mq.size() > 0));
            chk("out",   32'(instr_out),  (mq.size() > 0) ? 32'(mq[0][27:12]) : 32'h0);
            chk("immd",  32'(instr_immd), (mq.size() > 0) ? 32'(mq[0][11:0])  : 32'h0);
            chk("full",  32'(full),  32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
`ifdef IFQ_STATUS_EN
            chk("count",    32'(count),    32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe_word(input logic [15:0] w);
        @(negedge clk);
        we_IM  = 1'b1;
        codein = w;
        @(negedge clk);
        we_IM  = 1'b0;
    endtask

    task automatic pop1();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_on = 1'b1;
        tick();
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full",  32'(full), 32'h0);
        chk("rst_out",   32'(instr_out), 32'h0);
        chk("rst_immd",  32'(instr_immd), 32'h0);
        rst = 1'b0;
        en  = 1'b1;

        // Plain word: valid two edges after we_IM rises
        strobe_word(16'h6001);
        tick();
        chk("lit_6001_valid", 32'(instr_valid), 32'h1);
        chk("lit_6001_out",   32'(instr_out), 32'h6001);
        chk("lit_6001_immd",  32'(instr_immd), 32'h0);
        pop1();
        chk("lit_pop_empty", 32'(empty), 32'h1);

        // JUMP word with trailing immediate
        immd = 12'hFEB;
        strobe_word(16'h7111);
        repeat (IMM_WAIT + 1) tick();
        chk("lit_jump_out",  32'(instr_out), 32'h7111);
        chk("lit_jump_immd", 32'(instr_immd), 32'hFEB);
        pop1();
        strobe_word(16'h7021);
        tick();
        chk("lit_7021_out",  32'(instr_out), 32'h7021);
        chk("lit_7021_immd", 32'(instr_immd), 32'h0);
        pop1();

        // Level held high yields a single entry
        @(negedge clk);
        we_IM = 1'b1; codein = 16'h4000;
        repeat (5) tick();
        we_IM = 1'b0;
        repeat (2) tick();
        chk("lit_hold_out", 32'(instr_out), 32'h4000);
`ifdef IFQ_STATUS_EN
        chk("lit_hold_count", 32'(count), 32'h1);
`endif
        pop1();
        chk("lit_hold_empty", 32'(empty), 32'h1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 8; i++) strobe_word(16'h0010 + 16'(i));
        strobe_word(16'h9020);
        tick();
        chk("lit_full", 32'(full), 32'h1);
`ifdef IFQ_STATUS_EN
        chk("lit_overflow", 32'(overflow), 32'h1);
`endif
        for (int i = 0; i < 8; i++) begin
            chk("lit_drain", 32'(instr_out), 32'h10 + 32'(i));
            pop1();
        end
        chk("lit_drained_empty", 32'(empty), 32'h1);

        // Push into a full queue while the head leaves
        for (int i = 0; i < 8; i++) strobe_word(16'h0010 + 16'(i));
        tick();
        strobe_word(16'h9021);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("lit_pp_head", 32'(instr_out), 32'h0011);
        chk("lit_pp_full", 32'(full), 32'h1);
`ifdef IFQ_STATUS_EN
        chk("lit_pp_count", 32'(count), 32'h8);
`endif
        for (int i = 1; i < 8; i++) begin
            chk("lit_pp_drain", 32'(instr_out), 32'h10 + 32'(i));
            pop1();
        end
        chk("lit_pp_last", 32'(instr_out), 32'h9021);
        pop1();

        // Reset while waiting for a JUMP immediate
        strobe_word(16'h5555);
        tick();
        strobe_word(16'h7111);
        tick();
        #1 rst = 1'b1;
        #1;
        chk("lit_arst_valid", 32'(instr_valid), 32'h0);
        chk("lit_arst_empty", 32'(empty), 32'h1);
        chk("lit_arst_out",   32'(instr_out), 32'h0);
        chk("lit_arst_immd",  32'(instr_immd), 32'h0);
        tick();
        rst = 1'b0;
        repeat (IMM_WAIT + 3) tick();
        chk("lit_arst_nojump", 32'(instr_valid), 32'h0);

        // Randomized traffic in phases of differing drain pressure
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) we_IM = ~we_IM;
            codein = ($urandom_range(0, 3) == 0) ? {8'h71, 8'($urandom)} : 16'($urandom);
            immd   = 12'($urandom);
            en     = ($urandom_range(0, 9) != 0);
            case ((i / 1000) % 3)
                0:       instr_ready = ($urandom_range(0, 4) == 0);
                1:       instr_ready = ($urandom_range(0, 1) == 0);
                default: instr_ready = ($urandom_range(0, 4) != 0);
            endcase
        end
        we_IM = 1'b0;
        instr_ready = 1'b0;
        repeat (3) tick();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
